// File: rtl/pipe_hazard_sched.sv
// Stall/flush scheduler for the 5-stage pipeline. Controls are combinational from state and inputs (zero latency).
// Redirects outrank multi-cycle holds, which outrank load-use. A hold freezes PC/IF/ID and bubbles the stage behind it.
module pipe_hazard_sched #(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_write_reg,
  input  logic             ex_mc_op,
  input  logic             mem_branch_taken,
  input  logic             wb_jump,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             ex_hold,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

  localparam logic [7:0] MC_INIT = 8'(MC_CYCLES - 2);

  state_t     state, state_nxt;
  logic [7:0] mc_cnt, mc_cnt_nxt;
  logic       mc_skip, mc_skip_nxt;
  logic       redirect;
  logic       load_use;
  logic       mc_start;

  assign redirect = wb_jump | mem_branch_taken;

  // $0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_write_reg != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_write_reg)) ||
                     (id_uses_rt && (id_rt == ex_write_reg)));

  // mc_skip masks ex_mc_op for the one cycle the finished op drains into EX/MEM.
  assign mc_start = (state == RUN) && ex_mc_op && !mc_skip && !redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      mc_cnt  <= 8'd0;
      mc_skip <= 1'b0;
    end else begin
      state   <= state_nxt;
      mc_cnt  <= mc_cnt_nxt;
      mc_skip <= mc_skip_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mc_cnt_nxt  = mc_cnt;
    mc_skip_nxt = 1'b0;
    if (redirect) begin
      state_nxt  = RUN;
      mc_cnt_nxt = 8'd0;
    end else if (state == MC_BUSY) begin
      if (mc_cnt == 8'd0) begin
        state_nxt   = RUN;
        mc_skip_nxt = 1'b1;
      end else begin
        mc_cnt_nxt = mc_cnt - 8'd1;
      end
    end else if (mc_start) begin
      state_nxt  = MC_BUSY;
      mc_cnt_nxt = MC_INIT;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    ex_hold     = 1'b0;
    busy        = 1'b0;
    if (wb_jump) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (mem_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if ((state == MC_BUSY) || mc_start) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_flush = 1'b1;
      ex_hold     = 1'b1;
      busy        = (state == MC_BUSY);
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (!pc_write && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Bench for pipe_hazard_sched: directed and random stimulus scored against a cycle-level model.
// Expected outputs are queued at drive time and popped by a negedge monitor.
module tb_pipe_hazard_sched;

  localparam int MC_CYCLES = 4;
  localparam int CNT_W     = 16;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_write_reg;
  logic             id_uses_rs, id_uses_rt, ex_mem_read, ex_mc_op;
  logic             mem_branch_taken, wb_jump;
  logic             pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic             exmem_flush, memwb_flush, ex_hold, busy;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct packed {
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             ex_hold;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Model state: hold cycles still owed by an in-flight multi-cycle op,
  // whether ex_mc_op is to be ignored this cycle, and the stall total.
  int   m_busy_left;
  bit   m_ignore;
  int   m_stall;

  always #5 clk = ~clk;

  pipe_hazard_sched #(.MC_CYCLES(MC_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg), .ex_mc_op(ex_mc_op),
    .mem_branch_taken(mem_branch_taken), .wb_jump(wb_jump),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .ex_hold(ex_hold), .busy(busy), .stall_cnt(stall_cnt)
  );

  function automatic obs_t sample();
    obs_t o;
    o = '{pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
          exmem_flush, memwb_flush, ex_hold, busy, stall_cnt};
    return o;
  endfunction

  function automatic obs_t defaults(int cnt);
    obs_t e;
    e = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CNT_W'(cnt)};
    return e;
  endfunction

  function automatic obs_t predict();
    obs_t e;
    bit   lu;
    e  = defaults(m_stall);
    lu = ex_mem_read && ex_write_reg != 0 &&
         ((id_uses_rs && id_rs == ex_write_reg) || (id_uses_rt && id_rt == ex_write_reg));
    if (wb_jump) begin
      e.ifid_flush = 1; e.idex_flush = 1; e.exmem_flush = 1; e.memwb_flush = 1;
    end else if (mem_branch_taken) begin
      e.ifid_flush = 1; e.idex_flush = 1; e.exmem_flush = 1;
    end else if (m_busy_left > 0 || (ex_mc_op && !m_ignore)) begin
      e.pc_write = 0; e.ifid_write = 0; e.idex_write = 0;
      e.exmem_flush = 1; e.ex_hold = 1;
      e.busy = (m_busy_left > 0);
    end else if (lu) begin
      e.pc_write = 0; e.ifid_write = 0; e.idex_flush = 1;
    end
    return e;
  endfunction

  task automatic model_step(input obs_t e);
    bit was_ignore;
    was_ignore = m_ignore;
    m_ignore   = 0;
    if (wb_jump || mem_branch_taken) begin
      m_busy_left = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) m_ignore = 1;
    end else if (ex_mc_op && !was_ignore) begin
      m_busy_left = MC_CYCLES - 1;
    end
    if (!e.pc_write && m_stall < CNT_MAX) m_stall++;
  endtask

  task automatic model_reset();
    m_busy_left = 0;
    m_ignore    = 0;
    m_stall     = 0;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic mr, input logic [4:0] wr,
                        input logic mc, input logic br, input logic jmp);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_mem_read = mr; ex_write_reg = wr; ex_mc_op = mc;
    mem_branch_taken = br; wb_jump = jmp;
  endtask

  task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic mr, input logic [4:0] wr,
                       input logic mc, input logic br, input logic jmp);
    obs_t e;
    @(posedge clk);
    #1;
    set_in(rs, rt, urs, urt, mr, wr, mc, br, jmp);
    e = predict();
    exp_q.push_back(e);
    model_step(e);
  endtask

  task automatic idle();
    apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = sample();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got %b/%h, required %b/%h", $time,
                 a[CNT_W+8:CNT_W], a.stall_cnt, e[CNT_W+8:CNT_W], e.stall_cnt);
      end
    end
  end

  initial begin
    rst = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    check("reset_state", 32'(sample()), 32'(defaults(0)));
    #1 rst = 1'b1;

    // Load-use on rs, then rt, then $0 immunity and a non-matching register
    apply(5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    idle();
    apply(5'd9, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    apply(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    apply(5'd3, 5'd4, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    idle();

    // Multi-cycle op held for its full occupancy plus the drain cycle
    repeat (MC_CYCLES + 1) apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle();

    // Branch aborts the op on its second busy cycle
    repeat (2) apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    idle();

    // Jump, branch and load-use together
    apply(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1);
    apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    idle();

    // Random traffic with a small register set so dependencies are frequent
    for (int i = 0; i < 3000; i++) begin
      apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 19) == 0));
    end
    idle();

    // Asynchronous reset while the multi-cycle unit is busy
    repeat (2) apply(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset_defaults", 32'(sample()), 32'(defaults(0)));
    model_reset();
    rst = 1'b1;
    #1;
    begin
      obs_t e;
      e = predict();
      exp_q.push_back(e);
      model_step(e);
    end

    // Continuous load-use stall drives the counter into saturation
    repeat (CNT_MAX + 5) apply(5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    #1;
    check("stall_saturated", 32'(stall_cnt), 32'(CNT_MAX));

    @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_sched.md
Name: pipe_hazard_sched

Overview:
- Central stall/flush scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives write-enable and bubble-insert controls for the PC and the four pipeline registers.
- Covers load-use interlocks, multi-cycle EX operations (SAD accumulate/multiply), branch redirects resolved in MEM, and jump/jr/jal redirects resolved in WB.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
MC_CYCLES, 4, total EX occupancy in cycles of a multi-cycle op (legal range 2 to 255)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  instruction in ID reads rs
id_uses_rt  in  1  instruction in ID reads rt
ex_mem_read  in  1  instruction in EX is a load
ex_write_reg  in  5  destination register of the instruction in EX
ex_mc_op  in  1  instruction in EX is multi-cycle
mem_branch_taken  in  1  branch resolved taken in MEM
wb_jump  in  1  jump-class redirect valid in WB
pc_write  out  1  PC loads its next value
ifid_write  out  1  IF/ID register captures
ifid_flush  out  1  IF/ID loads a NOP
idex_write  out  1  ID/EX register captures
idex_flush  out  1  ID/EX loads a bubble (all control signals 0)
exmem_flush  out  1  EX/MEM loads a bubble
memwb_flush  out  1  MEM/WB loads a bubble
ex_hold  out  1  multi-cycle unit keeps iterating
busy  out  1  FSM is in MC_BUSY
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- States: RUN and MC_BUSY; 8-bit down-counter mc_cnt.
- Async reset (rst=0): state=RUN, mc_cnt=0, stall_cnt=0.
- Default outputs: pc_write=1, ifid_write=1, idex_write=1, all flushes=0, ex_hold=0, busy=0.
- All outputs are combinational from the current state and inputs; state and counters update on the rising clk edge.
- Priority, highest first: wb_jump, mem_branch_taken, MC_BUSY / multi-cycle start, load-use.
- wb_jump=1 (any state):
  - Assert ifid_flush, idex_flush, exmem_flush, memwb_flush.
  - pc_write=1.
  - Next state=RUN, mc_cnt=0 (aborts any in-flight multi-cycle op).
- mem_branch_taken=1 (and no wb_jump):
  - Assert ifid_flush, idex_flush, exmem_flush.
  - pc_write=1.
  - Next state=RUN, mc_cnt=0.
- Multi-cycle start, RUN and ex_mc_op=1 with no redirect:
  - Hold: pc_write=0, ifid_write=0, idex_write=0.
  - exmem_flush=1, ex_hold=1.
  - mc_cnt<=MC_CYCLES-2, next state=MC_BUSY.
- MC_BUSY, no redirect:
  - Same hold outputs, plus busy=1.
  - If mc_cnt≠0: mc_cnt decrements.
  - If mc_cnt=0: this is the last hold cycle; next state=RUN.
  - On the following cycle the EX result advances into EX/MEM normally (ex_mc_op from the same instruction is ignored in that cycle).
  - Total EX occupancy is exactly MC_CYCLES cycles.
- Load-use, RUN and no other higher-priority condition:
  - Condition: ex_mem_read=1, ex_write_reg≠0, and (id_uses_rs and id_rs==ex_write_reg, or id_uses_rt and id_rt==ex_write_reg).
  - Response: pc_write=0, ifid_write=0, idex_flush=1 for exactly one cycle.
  - $0 never creates a hazard.
- stall_cnt:
  - +1 on each clock where pc_write=0.
  - Saturates at all-ones.
  - Redirect cycles are not counted.
- memwb_flush is asserted only by wb_jump.
- Flush and write-enable on the same register: flush wins.

Test Plan:
- Load-use: lw $2 in EX (ex_write_reg=2, ex_mem_read=1), id_rs=2, id_uses_rs=1 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_cnt 0->1; next cycle all defaults.
- $0 immunity: same as load-use with ex_write_reg=0 -> no stall, stall_cnt stays 0.
- Multi-cycle, MC_CYCLES=4: ex_mc_op=1 in RUN -> pc_write=0 for exactly 4 cycles, busy=1 on cycles 2-4, exmem_flush=1 on cycles 1-4, cycle 5 defaults; stall_cnt=4.
- Branch abort: mem_branch_taken=1 on 2nd busy cycle -> ifid/idex/exmem flush, pc_write=1, state RUN, mc_cnt=0, busy=0 next cycle.
- Priority: wb_jump=1, mem_branch_taken=1 and load-use all in the same cycle -> all four flushes, pc_write=1, no stall counted.
- Reset mid-op: rst=0 asynchronously while busy -> immediate busy=0, stall_cnt=0, defaults; counting saturates at 0xFFFF under continuous stall with CNT_W=16.
